// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arb_pkg: shared types and defaults for the UART transmit arbiter.
package uart_tx_arb_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int PORT_TRACE = 0;
  localparam int PORT_STORE = 1;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular buffer with occupancy count; full pushes and empty pops are ignored.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_level;
  logic w_do_push, w_do_pop;
  assign w_do_push = i_push && (r_level < (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && (r_level != '0);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  always_ff @(posedge i_clk)
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  assign o_rdata = r_mem[r_rptr];
  assign o_level = r_level;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin merge of two byte producers into one FIFO feeding the UART transmitter.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req0_valid,
  input  logic [DATA_W-1:0]        i_req0_data,
  output logic                     o_req0_ready,
  input  logic                     i_req1_valid,
  input  logic [DATA_W-1:0]        i_req1_data,
  output logic                     o_req1_ready,
  output logic                     o_tx_valid,
  output logic [DATA_W-1:0]        o_tx_data,
  input  logic                     i_tx_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_busy
);
  localparam int LW = $clog2(DEPTH) + 1;
  state_t r_state;
  logic r_tx_valid, r_last_grant;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] w_rdata, w_wdata;
  logic [LW-1:0] w_level;
  logic w_can_push, w_grant0, w_grant1, w_push, w_pop;
  assign w_can_push = w_level < LW'(DEPTH);
  // Under contention the port that did not win last time is served.
  assign w_grant0 = w_can_push && i_req0_valid && (!i_req1_valid || r_last_grant);
  assign w_grant1 = w_can_push && i_req1_valid && (!i_req0_valid || !r_last_grant);
  assign w_push   = w_grant0 || w_grant1;
  assign w_wdata  = w_grant1 ? i_req1_data : i_req0_data;
  assign w_pop    = (w_level != '0) && (r_state == IDLE || i_tx_ready);
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_level (w_level)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_last_grant <= 1'(PORT_STORE);
    end else begin
      if (w_push) r_last_grant <= w_grant1;
      if (w_pop) begin
        r_tx_data  <= w_rdata;
        r_tx_valid <= 1'b1;
        r_state    <= SEND;
      end else if (r_state == SEND && i_tx_ready) begin
        r_tx_valid <= 1'b0;
        r_state    <= IDLE;
      end
    end
  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_tx_valid   = r_tx_valid;
  assign o_tx_data    = r_tx_data;
  assign o_level      = w_level;
  assign o_busy       = r_tx_valid || (w_level != '0);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random checks of the arbiter against a queue-based model.
module tb_uart_tx_arbiter;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_req0_valid = 1'b0, i_req1_valid = 1'b0, i_tx_ready = 1'b0;
  logic [7:0] i_req0_data = '0, i_req1_data = '0;
  logic o_req0_ready, o_req1_ready, o_tx_valid, o_busy;
  logic [7:0] o_tx_data;
  logic [2:0] o_level;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q[$];
  logic m_ov;
  logic [7:0] m_od;
  logic m_lg;
  always #5 clk = ~clk;
  uart_tx_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_req0_valid (i_req0_valid),
    .i_req0_data  (i_req0_data),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_data  (i_req1_data),
    .o_req1_ready (o_req1_ready),
    .o_tx_valid   (o_tx_valid),
    .o_tx_data    (o_tx_data),
    .i_tx_ready   (i_tx_ready),
    .o_level      (o_level),
    .o_busy       (o_busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset;
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    i_tx_ready = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk("rst_txv", 32'(o_tx_valid), 0);
    chk("rst_txd", 32'(o_tx_data), 0);
    chk("rst_lvl", 32'(o_level), 0);
    chk("rst_busy", 32'(o_busy), 0);
    q.delete();
    m_ov = 1'b0;
    m_od = '0;
    m_lg = 1'b1;
    @(posedge clk);
    #1 i_rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  // One clock: readies checked before the edge, registered outputs after it.
  task automatic cyc(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                     input logic rdy, output logic r0, output logic r1);
    logic can, g0, g1;
    i_req0_valid = v0;
    i_req0_data = d0;
    i_req1_valid = v1;
    i_req1_data = d1;
    i_tx_ready = rdy;
    #1;
    can = q.size() < DEPTH;
    g0 = can && v0 && (!v1 || m_lg);
    g1 = can && v1 && (!v0 || !m_lg);
    r0 = o_req0_ready;
    r1 = o_req1_ready;
    chk("ready0", 32'(r0), 32'(g0));
    chk("ready1", 32'(r1), 32'(g1));
    @(posedge clk);
    if (m_ov && rdy) m_ov = 1'b0;
    if (!m_ov && q.size() != 0) begin
      m_od = q.pop_front();
      m_ov = 1'b1;
    end
    if (g0) begin
      q.push_back(d0);
      m_lg = 1'b0;
    end else if (g1) begin
      q.push_back(d1);
      m_lg = 1'b1;
    end
    #1;
    chk("tx_valid", 32'(o_tx_valid), 32'(m_ov));
    chk("tx_data", 32'(o_tx_data), 32'(m_od));
    chk("level", 32'(o_level), 32'(q.size()));
    chk("busy", 32'(o_busy), 32'(m_ov || q.size() != 0));
  endtask
  initial begin
    logic r0, r1;
    int n0, n1, acc;
    logic [7:0] seen[$];
    logic [7:0] cexp[4];
    logic [2:0] b2b_lvl[3];
    logic b2b_txv[3];
    int pct[4];
    cexp = '{8'h10, 8'h20, 8'h11, 8'h21};
    b2b_lvl = '{3'd1, 3'd0, 3'd0};
    b2b_txv = '{1'b1, 1'b1, 1'b0};
    pct = '{20, 50, 80, 100};
    do_reset();
    cyc(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, r0, r1);
    chk("sb_ready0", 32'(r0), 1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, r0, r1);
    chk("sb_txv", 32'(o_tx_valid), 1);
    chk("sb_txd", 32'(o_tx_data), 32'hA5);
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, r0, r1);
    chk("sb_hold", 32'(o_tx_data), 32'hA5);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, r0, r1);
    chk("sb_txv_end", 32'(o_tx_valid), 0);
    chk("sb_busy_end", 32'(o_busy), 0);
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 8'(8'h10 + n0), 1'b1, 8'(8'h20 + n1), 1'b1, r0, r1);
      if (k < 4) chk("cont_grant0", 32'(r0), 32'(k % 2 == 0));
      n0 += int'(r0);
      n1 += int'(r1);
      if (o_tx_valid) seen.push_back(o_tx_data);
    end
    chk("cont_seen", 32'(seen.size() >= 4), 1);
    for (int k = 0; k < 4 && k < seen.size(); k++) chk("cont_order", 32'(seen[k]), 32'(cexp[k]));
    repeat (8) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, r0, r1);
    do_reset();
    acc = 0;
    repeat (6) begin
      cyc(1'b0, 8'h00, 1'b1, 8'(8'h30 + acc), 1'b0, r0, r1);
      acc += int'(r1);
    end
    chk("fill_accepted", 32'(acc), 5);
    chk("fill_level", 32'(o_level), 4);
    cyc(1'b0, 8'h00, 1'b1, 8'(8'h30 + acc), 1'b1, r0, r1);
    chk("fill_pulse_rdy", 32'(r1), 0);
    cyc(1'b0, 8'h00, 1'b1, 8'(8'h30 + acc), 1'b0, r0, r1);
    chk("fill_after_rdy", 32'(r1), 1);
    repeat (8) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, r0, r1);
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'h40 + k), 1'b0, 8'h00, 1'b0, r0, r1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, r0, r1);
    chk("b2b_lvl_start", 32'(o_level), 2);
    chk("b2b_txv_start", 32'(o_tx_valid), 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, r0, r1);
      chk("b2b_lvl", 32'(o_level), 32'(b2b_lvl[k]));
      chk("b2b_txv", 32'(o_tx_valid), 32'(b2b_txv[k]));
    end
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'(8'h50 + k), 1'b0, 8'h00, 1'b0, r0, r1);
    chk("mid_pre_lvl", 32'(o_level), 3);
    chk("mid_pre_txv", 32'(o_tx_valid), 1);
    do_reset();
    cyc(1'b1, 8'h60, 1'b1, 8'h70, 1'b0, r0, r1);
    chk("mid_grant0", 32'(r0), 1);
    chk("mid_grant1", 32'(r1), 0);
    do_reset();
    for (int b = 0; b < 4; b++)
      repeat (150)
        cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 99) < pct[b]), r0, r1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between two byte producers: the CPU register-trace path (port 0) and the memory-store debug path (port 1). Accepts bytes from either requester with round-robin arbitration, buffers them in a small FIFO, and feeds the UART transmit interface with a valid/ready handshake. It sits between the core datapath and the `uart` instance in the top level and replaces the direct data-to-UART wiring.

## Interface
- `DATA_W`, 8, byte width of every data path.
- `DEPTH`, 4, FIFO entries. Must be a power of two and ≥ 2.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  port 0 (register trace) has a byte.
- `req0_data`  in  DATA_W  port 0 byte.
- `req0_ready`  out  1  port 0 byte accepted this cycle (combinational).
- `req1_valid`, `req1_data`, `req1_ready`  same as port 0, for port 1 (store debug).
- `tx_valid`  out  1  registered; a byte is presented to the UART.
- `tx_data`  out  DATA_W  registered byte for the UART.
- `tx_ready`  in  1  the UART takes `tx_data` on this edge when `tx_valid` is high.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy. The output register is not counted.
- `busy`  out  1  `tx_valid | (level != 0)`.

## Operation
- **Push side.** A push is allowed only when `level < DEPTH`, evaluated on the current-cycle value.
  - No push happens in a full cycle, even if a pop happens in the same cycle.
- **Arbitration** uses register `last_grant`, reset value 1, so port 0 wins the first contention.
  - Both ports valid: grant the port ≠ `last_grant`.
  - One port valid: grant that port.
  - On a grant, `reqN_ready`=1 that cycle, the byte is written at the FIFO tail, and `last_grant` becomes N.
  - The non-granted ready is 0.
  - When no push is allowed, both readies are 0 and `last_grant` holds.
- **FIFO.** Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `level` changes by +1 on push only, −1 on pop only, and 0 when push and pop happen together.
- **Output FSM** has two states, IDLE and SEND.
  - IDLE: if `level != 0`, pop the head into `tx_data`, set `tx_valid`=1, and go to SEND. Otherwise stay.
  - SEND: hold `tx_data` and `tx_valid` stable while `tx_ready`=0.
  - SEND with `tx_ready`=1 and `level != 0`: pop the next head into `tx_data` and stay in SEND (back-to-back, no bubble).
  - SEND with `tx_ready`=1 and `level == 0`: set `tx_valid`=0 and go to IDLE.
- **Ordering.** Bytes leave in global acceptance order. Each port's bytes stay in order.
- **Reset values:** `tx_valid`=0, `tx_data`=0, `level`=0, `busy`=0, pointers=0, state=IDLE, `last_grant`=1.
  - Both readies read 0 only when `level` = DEPTH or neither port is valid.
- **Reset mid-operation.** Asserting `rst` discards FIFO contents and any byte in flight. `tx_valid` drops asynchronously.

## Timing
- **Acceptance.** A ready/valid handshake at edge N writes the FIFO at edge N.
- **Latency to UART.** With the FSM in IDLE, `tx_valid` rises after edge N+1: one cycle of latency from acceptance to presentation.
- **Sustained throughput.** One byte per cycle when `tx_ready` is held high.
- **Full FIFO with output stalled.** DEPTH bytes sit in the FIFO plus one in the output register. The readies stay 0 until the first pop frees a slot, and go to 1 in the cycle after that pop.
- **Deasserting valid.** A requester may drop valid without a handshake. No state changes in that case.

## Structure
- **Package `uart_tx_arb_pkg`:**
  - FSM state enum {IDLE, SEND};
  - default `DATA_W` and `DEPTH` constants;
  - port index constants `PORT_TRACE`=0 and `PORT_STORE`=1.
- **Sub-module `sync_fifo`** (parameters DATA_W and DEPTH; push, pop, wdata, rdata, level).
  - Arbitration and the FSM live in the top of this block.
  - `sync_fifo` is reusable for a later receive-side buffer.

## Test plan
- **Single byte.** After reset, pulse `req0_valid` with 0xA5 while `tx_ready`=0.
  - `req0_ready`=1 that cycle and `tx_valid`=1 with `tx_data`=0xA5 one cycle later.
  - The byte holds until `tx_ready`=1, then `tx_valid`=0 and `busy`=0.
- **Contention.** Hold both ports valid continuously (port 0 bytes 0x10,0x11,…; port 1 bytes 0x20,0x21,…) with `tx_ready`=1.
  - Grants alternate 0,1,0,1 and `tx_data` reads 0x10,0x20,0x11,0x21.
- **Fill.** Hold `tx_ready`=0 and push 6 bytes on port 1.
  - 5 are accepted (4 in the FIFO, 1 in the output register) and `level`=4 with `req1_ready`=0.
  - After one `tx_ready` pulse, the next byte is accepted one cycle later.
- **Back-to-back.** Preload 3 bytes, then hold `tx_ready`=1.
  - `tx_valid` stays high for 3 consecutive cycles and then falls.
  - `level` reads 2,1,0,0.
- **Reset mid-transfer.** Assert `rst` low while `tx_valid`=1 and `level`=3.
  - `tx_valid`, `level` and `busy` read 0 immediately.
  - After release, the first grant under contention goes to port 0.
